// File: rtl/conway_frame_scanner.sv
// -----------------------------------------------------------------------------
// conway_frame_scanner
//
// Purpose:
//   Snapshots the flattened state vector of a ROWS x COLS Conway cell grid and
//   streams it out one row per beat over a valid/ready interface. Drives the
//   shared cell enable so that the grid advances exactly one generation per
//   fully delivered frame. Frames free-run while i_run is high, or are issued
//   one at a time on i_step_req pulses (coalesced while a frame is in flight).
//
// Optional feature (macro CONWAY_POPCOUNT_EN):
//   Adds o_pop_count, the live-cell total of the last delivered frame, loaded
//   when the generation step fires.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_run        in   level; frames free-run while high
//   i_step_req   in   pulse; request one frame plus one generation
//   i_cells_q    in   ROWS*COLS live cell states, bit r*COLS+c = row r col c
//   o_cell_ena   out  one-cycle enable pulse to every cell
//   o_row_data   out  COLS bits of the presented snapshot row
//   o_row_idx    out  index of the presented row
//   o_row_valid  out  row beat valid
//   i_row_ready  in   consumer accepts the beat
//   o_frame_last out  high with o_row_valid on row ROWS-1
//   o_busy       out  registered, high whenever the FSM is not IDLE
//   o_gen_count  out  16-bit generation counter, wraps
//   o_pop_count  out  frame popcount (only with CONWAY_POPCOUNT_EN)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for run or a pending step request
// SNAP  | one cycle; grid is latched into the snapshot on exit
// SEND  | presenting snapshot rows, advancing on each accepted beat
// STEP  | one cycle; cell enable high, grid advances on exit
// HOLD  | GEN_DIV-1 cycles of spacing before returning to IDLE
// -----------------------------------------------------------------------------
module conway_frame_scanner #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int GEN_DIV = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_run,
    input  logic                           i_step_req,
    input  logic [ROWS*COLS-1:0]           i_cells_q,
    output logic                           o_cell_ena,
    output logic [COLS-1:0]                o_row_data,
    output logic [$clog2(ROWS)-1:0]        o_row_idx,
    output logic                           o_row_valid,
    input  logic                           i_row_ready,
    output logic                           o_frame_last,
    output logic                           o_busy,
`ifdef CONWAY_POPCOUNT_EN
    output logic [$clog2(ROWS*COLS+1)-1:0] o_pop_count,
`endif
    output logic [15:0]                    o_gen_count
);

    localparam int IW = $clog2(ROWS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

    // Hold counter is a down-counter loaded on the STEP exit edge; with
    // GEN_DIV==1 the HOLD state is skipped and the counter is never used.
    localparam int HW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (GEN_DIV > 1) ? HW'(GEN_DIV - 2) : '0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        SEND = 3'd2,
        STEP = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic                r_step_pending;
    logic [IW-1:0]       r_row_idx;
    logic [COLS-1:0]     r_snap [ROWS];
    logic [HW-1:0]       r_hold_cnt;
    logic [15:0]         r_gen_count;
    logic                w_xfer;
    logic                w_is_last;
    logic                w_start;

    assign w_is_last = (r_row_idx == LAST_IDX);
    assign w_xfer    = (r_state == SEND) && i_row_ready;
    assign w_start   = (r_state == IDLE) && (w_state_nxt == SNAP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (i_run || r_step_pending) w_state_nxt = SNAP;
            SNAP: w_state_nxt = SEND;
            SEND: if (w_xfer && w_is_last) w_state_nxt = STEP;
            STEP: w_state_nxt = (GEN_DIV > 1) ? HOLD : IDLE;
            HOLD: if (r_hold_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_step_pending <= 1'b0;
            r_row_idx      <= '0;
            r_hold_cnt     <= '0;
            r_gen_count    <= '0;
            for (int r = 0; r < ROWS; r++) r_snap[r] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);

            // Clearing on frame start wins over a coincident request, so a
            // pulse landing in the exit cycle does not produce a second frame.
            if (w_start)
                r_step_pending <= 1'b0;
            else if (i_step_req)
                r_step_pending <= 1'b1;

            if (r_state == SNAP) begin
                r_row_idx <= '0;
                for (int r = 0; r < ROWS; r++)
                    r_snap[r] <= i_cells_q[r*COLS +: COLS];
            end else if (w_xfer && !w_is_last) begin
                r_row_idx <= r_row_idx + 1'b1;
            end

            if (r_state == STEP)
                r_hold_cnt <= HOLD_LOAD;
            else if (r_state == HOLD && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - 1'b1;

            if (r_state == STEP)
                r_gen_count <= r_gen_count + 16'd1;
        end
    end

`ifdef CONWAY_POPCOUNT_EN
    localparam int PW = $clog2(ROWS*COLS+1);

    logic [PW-1:0] r_pop_acc;
    logic [PW-1:0] r_pop_count;

    function automatic logic [PW-1:0] f_popcnt(input logic [COLS-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < COLS; i++) s = s + PW'(v[i]);
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_acc   <= '0;
            r_pop_count <= '0;
        end else begin
            if (r_state == SNAP)
                r_pop_acc <= '0;
            else if (w_xfer)
                r_pop_acc <= r_pop_acc + f_popcnt(o_row_data);

            if (r_state == STEP)
                r_pop_count <= r_pop_acc;
        end
    end

    assign o_pop_count = r_pop_count;
`endif

    assign o_cell_ena   = (r_state == STEP);
    assign o_row_valid  = (r_state == SEND);
    assign o_frame_last = (r_state == SEND) && w_is_last;
    assign o_row_data   = r_snap[r_row_idx];
    assign o_row_idx    = r_row_idx;
    assign o_busy       = r_busy;
    assign o_gen_count  = r_gen_count;

endmodule

// File: doc/conway_frame_scanner.md
Name: conway_frame_scanner

Overview:
- Downstream stage of the Conway cell array. Snapshots the flattened state_q vector of a ROWS x COLS grid and streams it out one row per beat over a valid/ready interface.
- Drives the shared ena line of every cell, so the grid advances exactly one generation per fully delivered frame.
- Sits between the cell grid and the display or host consumer.

Parameters:
- ROWS, 8, grid rows; must be >= 2.
- COLS, 8, grid columns; must be >= 1.
- GEN_DIV, 4, minimum number of cycles from the cell_ena pulse back to IDLE; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; while high, frames and generations free-run.
- step_req  input  1  single-cycle pulse; requests one frame plus one generation.
- cells_q  input  ROWS*COLS  live cell states; bit r*COLS+c is row r, column c.
- cell_ena  output  1  to the ena input of every cell; one-cycle pulse per generation.
- row_data  output  COLS  snapshot row; bit c is column c.
- row_idx  output  $clog2(ROWS)  index of the row currently presented.
- row_valid  output  1  row_data and row_idx are valid.
- row_ready  input  1  consumer accepts the beat.
- frame_last  output  1  high with row_valid on row ROWS-1.
- busy  output  1  high in any state other than IDLE.
- gen_count  output  16  number of generations stepped; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (rst_n low, asynchronous): state becomes IDLE. cell_ena, row_valid, frame_last, busy, step_pending, gen_count, row_idx, the snapshot register and the hold counter all go to 0. Reset may assert in any state; any frame in flight is abandoned with no cell_ena pulse.
- step_pending flag: set on any cycle with step_req=1, in any state. Cleared on the IDLE->SNAP transition. Multiple pulses during one frame collapse into one pending request.
- FSM states: IDLE, SNAP, SEND, STEP, HOLD.
- IDLE: if (run | step_pending), go to SNAP on the next edge. Otherwise stay.
- SNAP: one cycle. On the exit edge, latch cells_q into the snapshot and set row_idx=0. Go to SEND.
- SEND:
  - row_valid=1; row_data = snapshot row row_idx; frame_last = (row_idx==ROWS-1).
  - A beat transfers on any edge where row_valid & row_ready.
  - On a transfer with row_idx<ROWS-1: increment row_idx.
  - On a transfer of row ROWS-1: go to STEP.
  - While row_valid & !row_ready, row_data, row_idx and frame_last hold stable. row_valid never drops before the transfer.
  - Changes on cells_q during SEND are ignored; the snapshot is frozen.
- STEP: exactly one cycle with cell_ena=1. gen_count increments on the exit edge. Go to HOLD.
- HOLD: stay GEN_DIV-1 cycles (0 extra cycles when GEN_DIV=1), then go to IDLE.
- Cell ena is therefore low at every edge except the one ending STEP. The cells update their state_q at that edge.
- Latency:
  - The first row is valid 2 cycles after the IDLE cycle that saw the request.
  - With row_ready tied high, the frame period is 1 (IDLE) + 1 (SNAP) + ROWS + 1 (STEP) + (GEN_DIV-1) cycles.
- run deasserted mid-frame: the current frame completes, including STEP and HOLD, then the block stays in IDLE.
- Simultaneous step_req in the IDLE cycle that exits on run: the pending flag is still cleared, so only one frame is produced.
- busy is a registered decode of state != IDLE.

Optional Feature:
- Macro: CONWAY_POPCOUNT_EN.
- When defined:
  - Adds output pop_count, width $clog2(ROWS*COLS+1), reset 0.
  - An internal accumulator clears in SNAP and adds the popcount of each transferred row.
  - pop_count loads the frame total on the STEP exit edge and holds until the next frame's STEP.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_n low mid-SEND on row 3 -> the same cycle shows row_valid=0, busy=0, cell_ena=0; after release, gen_count=0 and no cell_ena until a new request arrives.
- Single step, 8x8 grid, horizontal blinker on row 4, cols 3-5, row_ready=1: pulse step_req -> 8 beats, row 4 data = 8'b0011_1000, frame_last on beat 8, one cell_ena pulse, gen_count=1; the next frame (second step_req) shows the vertical blinker in rows 3-5 at col 4 (8'b0001_0000 each).
- Backpressure: hold row_ready=0 for 5 cycles on row 2 -> row_data and row_idx=2 stay stable with row_valid=1; no cell_ena until row 7 is accepted.
- Free-run, run=1, GEN_DIV=4, row_ready=1 -> cell_ena period exactly 1+1+8+1+3 = 14 cycles; gen_count counts 1,2,3...; deasserting run mid-SEND yields exactly one more cell_ena.
- Request coalescing: 3 step_req pulses during one SEND -> exactly one additional frame after HOLD, then IDLE.
- CONWAY_POPCOUNT_EN: glider (5 live cells) -> pop_count=5 after STEP; an all-ones grid gives 64; gen_count wrap is checked by forcing it to 16'hFFFF and stepping -> 0.
